// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, write-back selector encoding and WB buffer layout
package wb_stage_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 3;
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   typedef enum logic [1:0] {
      WB_SEL_ALU = 2'd0,
      WB_SEL_MEM = 2'd1,
      WB_SEL_IMM = 2'd2,
      WB_SEL_IN  = 2'd3
   } wb_sel_t;
   typedef struct packed {
      logic [DATA_WIDTH-1:0] ex_result;
      logic [DATA_WIDTH-1:0] memory_data;
      logic [DATA_WIDTH-1:0] immediate;
      logic [DATA_WIDTH-1:0] input_port;
      wb_sel_t               wb_selector;
      logic                  write_back;
      logic [ADDR_WIDTH-1:0] write_addr;
      logic                  out_en;
   } wb_buf_t;
endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: execute-memory/decode/hazard-facing signals of the write-back stage
interface wb_stage_if;
   import wb_stage_pkg::*;
   logic                  i_stall;
   logic                  i_flush;
   logic [DATA_WIDTH-1:0] i_ex_result;
   logic [DATA_WIDTH-1:0] i_memory_data;
   logic [DATA_WIDTH-1:0] i_immediate;
   logic [DATA_WIDTH-1:0] i_input_port;
   logic [1:0]            i_wb_selector;
   logic                  i_write_back;
   logic [ADDR_WIDTH-1:0] i_write_addr;
   logic                  i_out_en;
   logic [ADDR_WIDTH-1:0] i_read_addr1;
   logic [ADDR_WIDTH-1:0] i_read_addr2;
   logic [DATA_WIDTH-1:0] o_read_data1;
   logic [DATA_WIDTH-1:0] o_read_data2;
   logic [DATA_WIDTH-1:0] o_data_wb;
   logic                  o_write_back;
   logic [ADDR_WIDTH-1:0] o_write_addr;
   logic [DATA_WIDTH-1:0] o_out_port;
   modport master (
      output i_stall, i_flush, i_ex_result, i_memory_data, i_immediate, i_input_port,
      output i_wb_selector, i_write_back, i_write_addr, i_out_en, i_read_addr1, i_read_addr2,
      input  o_read_data1, o_read_data2, o_data_wb, o_write_back, o_write_addr, o_out_port
   );
   modport slave (
      input  i_stall, i_flush, i_ex_result, i_memory_data, i_immediate, i_input_port,
      input  i_wb_selector, i_write_back, i_write_addr, i_out_en, i_read_addr1, i_read_addr2,
      output o_read_data1, o_read_data2, o_data_wb, o_write_back, o_write_addr, o_out_port
   );
endinterface

// File: rtl/wb_stage_register_file.sv
// wb_stage_register_file: 8x16 register file, one sync write port, two bypassed comb read ports
module wb_stage_register_file
   import wb_stage_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2
);
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   always_ff @(posedge clk) begin
      if (rst)
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      else if (we)
         regs[waddr] <= wdata;
   end
   // Reads during reset return zero so decode never sees pre-reset contents
   always_comb begin
      rdata1 = rst ? '0 : (we && raddr1 == waddr) ? wdata : regs[raddr1];
      rdata2 = rst ? '0 : (we && raddr2 == waddr) ? wdata : regs[raddr2];
   end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: EX/MEM->WB buffer, write-back mux, register file and OUT port register
module wb_stage
   import wb_stage_pkg::*;
(
   input logic       i_clk,
   input logic       i_reset,
   wb_stage_if.slave bus
);
   wb_buf_t               buf_q;
   wb_buf_t               capture;
   logic [DATA_WIDTH-1:0] mux_data;
   logic [DATA_WIDTH-1:0] out_q;
   always_comb begin
      capture = '{bus.i_ex_result, bus.i_memory_data, bus.i_immediate, bus.i_input_port,
                  wb_sel_t'(bus.i_wb_selector), bus.i_write_back, bus.i_write_addr, bus.i_out_en};
   end
   always_ff @(posedge i_clk) begin
      if (i_reset || bus.i_flush)
         buf_q <= '0;
      else if (!bus.i_stall)
         buf_q <= capture;
   end
   always_comb begin
      mux_data = buf_q.wb_selector == WB_SEL_ALU ? buf_q.ex_result :
                 buf_q.wb_selector == WB_SEL_MEM ? buf_q.memory_data :
                 buf_q.wb_selector == WB_SEL_IMM ? buf_q.immediate : buf_q.input_port;
   end
   always_ff @(posedge i_clk) begin
      if (i_reset)
         out_q <= '0;
      else if (buf_q.out_en)
         out_q <= mux_data;
   end
   // Forwarding outputs read as idle while reset is asserted
   always_comb begin
      bus.o_data_wb    = i_reset ? '0 : mux_data;
      bus.o_write_back = buf_q.write_back & ~i_reset;
      bus.o_write_addr = i_reset ? '0 : buf_q.write_addr;
      bus.o_out_port   = out_q;
   end
   wb_stage_register_file u_rf (
      .clk    (i_clk),
      .rst    (i_reset),
      .we     (buf_q.write_back),
      .waddr  (buf_q.write_addr),
      .wdata  (mux_data),
      .raddr1 (bus.i_read_addr1),
      .raddr2 (bus.i_read_addr2),
      .rdata1 (bus.o_read_data1),
      .rdata2 (bus.o_read_data2)
   );
endmodule
